// File: rtl/lcd_ci_sequencer.sv
// ============================================================================
// Module   : lcd_ci_sequencer
// Purpose  : Nios II multi-cycle custom instruction sequencing HD44780 LCD
//            write cycles (RS/data setup, EN pulse, hold, execution wait).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_ci_sequencer #(
  parameter int   BUS_WIDTH       = 8,
  parameter int   SETUP_CYCLES    = 2,
  parameter int   EN_CYCLES       = 12,
  parameter int   HOLD_CYCLES     = 2,
  parameter int   CMD_WAIT_CYCLES = 2000,
  parameter int   CLR_WAIT_CYCLES = 82000,
  parameter logic BACKLIGHT_RST   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 start,
  input  logic [31:0]          dataa,
  input  logic [31:0]          datab,
  output logic                 done,
  output logic [31:0]          result,
  output logic [BUS_WIDTH-1:0] lcd_data,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_en,
  output logic                 lcd_backlight
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(SETUP_CYCLES, EN_CYCLES),
                                     max2(HOLD_CYCLES, CMD_WAIT_CYCLES)),
                                CLR_WAIT_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [7:0] OP_CMD  = 8'h00;
  localparam logic [7:0] OP_DATA = 8'h01;
  localparam logic [7:0] OP_BL   = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EN_HI = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     wait_ld_q, wait_ld_d;
  logic                 nib_q, nib_d;
  logic [BUS_WIDTH-1:0] lo_q, lo_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 rs_q, rs_d;
  logic                 en_q, en_d;
  logic                 bl_q, bl_d;
  logic [31:0]          result_q, result_d;

  logic [7:0]           opcode;
  logic [BUS_WIDTH-1:0] first_in;
  logic [BUS_WIDTH-1:0] second_in;
  logic                 is_clear;
  logic                 unused_hi;

  assign opcode    = dataa[7:0];
  assign unused_hi = ^{dataa[31:8], datab[31:8]};
  assign is_clear  = (datab[7:0] == 8'h01) || (datab[7:0] == 8'h02) ||
                     (datab[7:0] == 8'h03);

  // In 4-bit mode the high nibble goes out first; the low nibble is parked
  // in lo_q for the second SETUP/EN_HI/HOLD pass.
  generate
    if (BUS_WIDTH == 8) begin : g_bus8
      assign first_in  = datab[7:0];
      assign second_in = datab[7:0];
    end else begin : g_bus4
      assign first_in  = datab[7:4];
      assign second_in = datab[3:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wait_ld_q <= '0;
      nib_q     <= 1'b0;
      lo_q      <= '0;
      data_q    <= '0;
      rs_q      <= 1'b0;
      en_q      <= 1'b0;
      bl_q      <= BACKLIGHT_RST;
      result_q  <= '0;
    end else if (clk_en) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_ld_q <= wait_ld_d;
      nib_q     <= nib_d;
      lo_q      <= lo_d;
      data_q    <= data_d;
      rs_q      <= rs_d;
      en_q      <= en_d;
      bl_q      <= bl_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_ld_d = wait_ld_q;
    nib_d     = nib_q;
    lo_d      = lo_q;
    data_d    = data_q;
    rs_d      = rs_q;
    en_d      = en_q;
    bl_d      = bl_q;
    result_d  = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((opcode == OP_CMD) || (opcode == OP_DATA)) begin
            state_d   = ST_SETUP;
            cnt_d     = SETUP_LD;
            nib_d     = 1'b0;
            lo_d      = second_in;
            data_d    = first_in;
            rs_d      = opcode[0];
            result_d  = '0;
            wait_ld_d = ((opcode == OP_CMD) && is_clear) ? CLR_LD : CMD_LD;
          end else if (opcode == OP_BL) begin
            bl_d     = datab[0];
            result_d = '0;
            state_d  = ST_DONE;
          end else begin
            result_d = '1;
            state_d  = ST_DONE;
          end
        end
      end

      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_EN_HI;
          cnt_d   = EN_LD;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_EN_HI: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          if ((BUS_WIDTH == 4) && !nib_q) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            nib_d   = 1'b1;
            data_d  = lo_q;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = wait_ld_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign done          = (state_q == ST_DONE);
  assign result        = result_q;
  assign lcd_data      = data_q;
  assign lcd_rs        = rs_q;
  assign lcd_rw        = 1'b0;
  assign lcd_en        = en_q;
  assign lcd_backlight = bl_q;

endmodule

`default_nettype wire
